sdram_frame_writer: RTL and testbench
=====================================

SDRAM_FRAME_WRITER -- requirements
Module: sdram_frame_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, pixel/word width.
REQ-002 Parameter FIFO_DEPTH, default 16, entries in the elastic buffer; power of two, at least 4.
REQ-003 Parameter FRAME_PIXELS, default 76800, words per frame; at most 2^18.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sdram_init_done  input  1  SDRAM controller initialisation complete.
REQ-007 frame_start  input  1  one-cycle pulse marking the start of a frame.
REQ-008 pix_valid  input  1  pix_data valid this cycle; no back-pressure toward the source.
REQ-009 pix_data  input  DATA_WIDTH  pixel word.
REQ-010 write_enable  output  1  write request to the SDRAM controller wrapper.
REQ-011 write_addr  output  18  word address of the current request.
REQ-012 write_data  output  DATA_WIDTH  data of the current request.
REQ-013 write_ready  input  1  wrapper accepts the request; a transfer is write_enable && write_ready in the same cycle.
REQ-014 fifo_full  output  1  buffer holds FIFO_DEPTH entries.
REQ-015 overflow  output  1  sticky flag: a pixel was dropped in the current frame.
REQ-016 frame_done  output  1  one-cycle pulse after the last word of a frame transfers.

Function
REQ-017 The state machine SHALL have four states: WAIT_INIT, WAIT_FRAME, STREAM and DRAIN.
- WAIT_INIT -> WAIT_FRAME when sdram_init_done=1.
- WAIT_FRAME -> STREAM on frame_start.
- STREAM -> DRAIN when the FRAME_PIXELS-th pixel is pushed.
- DRAIN -> WAIT_FRAME when the final word transfers.
REQ-018 Pixels SHALL be pushed only in STREAM; pix_valid in any other state SHALL be ignored and SHALL NOT set overflow.
REQ-019 write_enable SHALL be 1 exactly when the state is STREAM or DRAIN and the FIFO is non-empty; write_data SHALL be the FIFO head.
REQ-020 A pixel pushed into an empty FIFO at edge N SHALL appear on write_data with write_enable=1 in the cycle following edge N (1-cycle latency).
REQ-021 While write_enable=1 and write_ready=0, write_enable, write_addr and write_data SHALL remain stable.
REQ-022 write_addr SHALL be 0 at frame_start and SHALL increment by 1 per transfer; after the transfer at FRAME_PIXELS-1 it SHALL return to 0.
REQ-023 frame_done SHALL pulse for one cycle in the cycle after the transfer at address FRAME_PIXELS-1.
REQ-024 A push and a pop in the same cycle SHALL be legal at any occupancy, including full; occupancy is then unchanged.
REQ-025 When pix_valid=1 while full with no pop in that cycle, the pixel SHALL be dropped, overflow SHALL be set, and pointers SHALL be unchanged.
REQ-026 Dropped pixels SHALL still count toward FRAME_PIXELS for the STREAM->DRAIN transition, so a frame always ends.
REQ-027 overflow SHALL clear on frame_start.
REQ-028 frame_start in STREAM or DRAIN (resync) SHALL take effect as follows:
- flush the FIFO;
- reset write_addr and the pixel count to 0;
- enter STREAM;
- suppress write_enable in the following cycle, even if a request was pending;
- raise no frame_done.
REQ-029 A frame_start coincident with pix_valid SHALL push that pixel as pixel 0 of the new frame.
REQ-030 sdram_init_done falling in any state SHALL force WAIT_INIT and flush the FIFO.

Reset
REQ-031 While rst_n=0, the block SHALL force:
- state WAIT_INIT, FIFO empty, write_addr 0, pixel count 0;
- write_enable 0, write_data 0, fifo_full 0, overflow 0, frame_done 0.
REQ-032 Reset assertion mid-transfer SHALL abort the frame with no further requests after release until a new frame_start.

Configuration
REQ-033 With macro SDRAM_FRAME_WRITER_OVF_CNT_EN defined, the block SHALL add output ovf_count (16 bits):
- counts dropped pixels and saturates at 16'hFFFF;
- clears on frame_start and on reset.
REQ-034 Without SDRAM_FRAME_WRITER_OVF_CNT_EN, ovf_count and its counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-035 Reset, init_done=1, frame_start, FRAME_PIXELS=8, 8 consecutive pixels 0x0001..0x0008, write_ready=1 -> 8 transfers at addr 0..7 with matching data, then frame_done pulses once, then state WAIT_FRAME.
REQ-036 write_ready=0 for 20 cycles with FIFO_DEPTH=16 and 20 pixels pushed -> fifo_full=1, overflow=1, 4 pixels dropped (ovf_count=4 if enabled); write outputs stable throughout; after release, 16 transfers occur and frame_done fires.
REQ-037 Full FIFO with simultaneous push and pop for 10 cycles -> no overflow, occupancy constant, data order preserved.
REQ-038 frame_start mid-frame at addr 5 with 3 words buffered -> FIFO flushed, write_enable 0 in the next cycle, the next transfer at addr 0 with the new pixel, no frame_done.
REQ-039 rst_n pulsed low while write_enable=1 -> all outputs 0 immediately; no request until init_done and frame_start.

Source files
------------

// File: rtl/sdram_frame_writer.sv
// Buffers a pixel stream in a small FIFO and issues one SDRAM word write per pixel.
// Define SDRAM_FRAME_WRITER_OVF_CNT_EN to add a saturating dropped-pixel counter (ovf_count).
module sdram_frame_writer #(
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sdram_init_done,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  write_enable,
  output logic [17:0]           write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_ready,
  output logic                  fifo_full,
  output logic                  overflow,
  output logic                  frame_done
`ifdef SDRAM_FRAME_WRITER_OVF_CNT_EN
  ,
  output logic [15:0]           ovf_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [17:0] LAST_PIX = 18'(FRAME_PIXELS - 1);
  localparam logic [AW:0] DEPTH    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE      = (AW + 1)'(1);

  typedef enum logic [1:0] {WAIT_INIT, WAIT_FRAME, STREAM, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]           count_reg;
  logic [17:0]           addr_reg, pix_count_reg, pix_count_base;
  logic                  suppress_reg, overflow_reg, frame_done_reg;
  logic                  active, empty, full, start, flush, accept;
  logic                  pop, push, drop, last_pixel, final_xfer;

  always_comb begin
    state_next     = state_reg;
    active         = (state_reg == STREAM) || (state_reg == DRAIN);
    empty          = (count_reg == '0);
    full           = (count_reg == DEPTH);
    // The cycle after a resync is held quiet even though pixel 0 may be buffered.
    write_enable   = active && !empty && !suppress_reg;
    write_data     = empty ? '0 : mem[rd_ptr_reg];
    pop            = write_enable && write_ready;
    start          = sdram_init_done && frame_start && (state_reg != WAIT_INIT);
    flush          = start || !sdram_init_done;
    accept         = pix_valid && sdram_init_done && (start || state_reg == STREAM);
    push           = accept && (flush || !full || pop);
    drop           = accept && !push;
    pix_count_base = start ? '0 : pix_count_reg;
    // Dropped pixels still advance the count so every frame terminates.
    last_pixel     = accept && (pix_count_base == LAST_PIX);
    final_xfer     = pop && (state_reg == DRAIN) && (count_reg == ONE) && !flush;

    if (!sdram_init_done) begin
      state_next = WAIT_INIT;
    end else if (start) begin
      state_next = last_pixel ? DRAIN : STREAM;
    end else begin
      case (state_reg)
        WAIT_INIT:  state_next = WAIT_FRAME;
        WAIT_FRAME: state_next = WAIT_FRAME;
        STREAM:     if (last_pixel) state_next = DRAIN;
        DRAIN:      if (final_xfer) state_next = WAIT_FRAME;
        default:    state_next = WAIT_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= WAIT_INIT;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      addr_reg       <= '0;
      pix_count_reg  <= '0;
      suppress_reg   <= 1'b0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= push ? AW'(1) : '0;
        rd_ptr_reg <= '0;
        count_reg  <= push ? ONE : '0;
        addr_reg   <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + (AW + 1)'(push) - (AW + 1)'(pop);
        if (pop) addr_reg <= (addr_reg == LAST_PIX || final_xfer) ? '0 : addr_reg + 18'd1;
      end

      if (!sdram_init_done) pix_count_reg <= '0;
      else if (accept)      pix_count_reg <= last_pixel ? '0 : pix_count_base + 18'd1;
      else if (start)       pix_count_reg <= '0;

      suppress_reg   <= start && active;
      frame_done_reg <= final_xfer;
      if (start)     overflow_reg <= 1'b0;
      else if (drop) overflow_reg <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[flush ? '0 : wr_ptr_reg] <= pix_data;
  end

  assign write_addr = addr_reg;
  assign fifo_full  = full;
  assign overflow   = overflow_reg;
  assign frame_done = frame_done_reg;

`ifdef SDRAM_FRAME_WRITER_OVF_CNT_EN
  logic [15:0] ovf_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ovf_count_reg <= '0;
    else if (start)                            ovf_count_reg <= '0;
    else if (drop && ovf_count_reg != 16'hFFFF) ovf_count_reg <= ovf_count_reg + 16'd1;
  end

  assign ovf_count = ovf_count_reg;
`endif

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed plus random stimulus for sdram_frame_writer, checked every cycle
// against a queue-based model of the frame/FIFO behaviour.
module tb_sdram_frame_writer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int FP    = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sdram_init_done = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          write_enable;
  logic [17:0]   write_addr;
  logic [DW-1:0] write_data;
  logic          write_ready = 1'b0;
  logic          fifo_full;
  logic          overflow;
  logic          frame_done;

  sdram_frame_writer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_data(pix_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .write_ready(write_ready), .fifo_full(fifo_full), .overflow(overflow),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // phase: 0 waiting for init, 1 waiting for frame, 2 accepting pixels, 3 draining
  int            phase;
  logic [DW-1:0] q[$];
  int            addr, pcount;
  bit            ovf, supp, fdone;
  int            checks = 0, fails = 0;
  int            fd_seen = 0, fd_exp = 0;
  bit            init_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    phase = 0; addr = 0; pcount = 0;
    ovf = 0; supp = 0; fdone = 0;
  endtask

  function automatic bit exp_we();
    return (phase >= 2) && (q.size() > 0) && !supp;
  endfunction

  task automatic model_step(input bit init, input bit fs, input bit pv,
                            input logic [DW-1:0] pd, input bit rdy);
    bit pop, start, fin;
    int old;
    pop   = exp_we() && rdy;
    start = init && fs && (phase != 0);
    if (pop) $display("xfer addr=%0d data=%04h", addr, q[0]);
    if (!init) begin
      q.delete();
      phase = 0; addr = 0; pcount = 0; supp = 0; fdone = 0;
    end else if (start) begin
      supp = (phase >= 2);
      q.delete();
      addr = 0; ovf = 0; fdone = 0; pcount = 0; phase = 2;
      if (pv) begin q.push_back(pd); pcount = 1; end
      if (pcount == FP) begin phase = 3; pcount = 0; end
    end else begin
      old = phase;
      fin = pop && (old == 3) && (q.size() == 1);
      if (pop) begin
        void'(q.pop_front());
        addr = fin ? 0 : (addr + 1) % FP;
      end
      if (old == 2 && pv) begin
        if (q.size() < DEPTH) q.push_back(pd);
        else ovf = 1;
        pcount++;
        if (pcount == FP) begin phase = 3; pcount = 0; end
      end
      if (old == 0 || fin) phase = 1;
      supp  = 0;
      fdone = fin;
    end
  endtask

  task automatic check_outputs();
    if (frame_done === 1'b1) fd_seen++;
    if (fdone) fd_exp++;
    chk("write_enable", 32'(write_enable), 32'(exp_we()));
    chk("write_addr",   32'(write_addr),   32'(addr));
    chk("write_data",   32'(write_data),   (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("fifo_full",    32'(fifo_full),    32'(q.size() == DEPTH));
    chk("overflow",     32'(overflow),     32'(ovf));
    chk("frame_done",   32'(frame_done),   32'(fdone));
  endtask

  task automatic step(input bit pv, input logic [DW-1:0] pd, input bit fs, input bit rdy);
    pix_valid = pv; pix_data = pd; frame_start = fs; write_ready = rdy;
    sdram_init_done = init_v;
    model_step(init_v, fs, pv, pd, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  initial begin
    logic [DW-1:0] saved;
    model_reset();

    // reset state
    repeat (3) begin @(negedge clk); check_outputs(); end
    rst_n = 1'b1;

    // frame_start ignored before init completes
    init_v = 0;
    repeat (3) step(1'b1, rnd(), 1'b1, 1'b1);
    init_v = 1;
    step(1'b0, '0, 1'b0, 1'b1);

    // full frame with continuous ready
    step(1'b1, 16'h0001, 1'b1, 1'b1);
    for (int i = 2; i <= FP; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);
    chk("frame_done_once", 32'(fd_seen), 32'd1);

    // stalled writer: buffer fills, 4 pixels dropped
    step(1'b1, rnd(), 1'b1, 1'b0);
    repeat (FP - 1) step(1'b1, rnd(), 1'b0, 1'b0);
    chk("stall_full", 32'(fifo_full), 32'd1);
    chk("stall_overflow", 32'(overflow), 32'd1);
    repeat (18) step(1'b0, '0, 1'b0, 1'b1);
    chk("stall_frame_done", 32'(fd_seen), 32'd2);

    // full buffer with simultaneous push and pop
    step(1'b1, rnd(), 1'b1, 1'b0);
    repeat (DEPTH - 1) step(1'b1, rnd(), 1'b0, 1'b0);
    repeat (FP - DEPTH) step(1'b1, rnd(), 1'b0, 1'b1);
    chk("pushpop_no_overflow", 32'(overflow), 32'd0);
    chk("pushpop_still_full", 32'(fifo_full), 32'd1);
    repeat (18) step(1'b0, '0, 1'b0, 1'b1);

    // resync at address 5 with 3 words buffered
    step(1'b1, rnd(), 1'b1, 1'b0);
    repeat (7) step(1'b1, rnd(), 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0, 1'b1);
    chk("resync_pre_addr", 32'(write_addr), 32'd5);
    saved = rnd();
    step(1'b1, saved, 1'b1, 1'b1);
    chk("resync_we_low", 32'(write_enable), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("resync_addr0", 32'(write_addr), 32'd0);
    chk("resync_data", 32'(write_data), 32'(saved));
    chk("resync_no_done", 32'(fd_seen), 32'd3);

    // random traffic with occasional resyncs and init drops
    for (int i = 0; i < 300; i++) begin
      init_v = ($urandom_range(0, 149) != 0);
      step($urandom_range(0, 99) < 70, rnd(), $urandom_range(0, 49) == 0,
           $urandom_range(0, 99) < 60);
    end

    // reset asserted mid-request
    init_v = 1;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, rnd(), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pre_reset_we", 32'(write_enable), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    repeat (5) step(1'b1, rnd(), 1'b0, 1'b1);
    step(1'b1, rnd(), 1'b1, 1'b1);
    repeat (24) step(1'b1, rnd(), 1'b0, 1'b1);
    chk("frame_done_total", 32'(fd_seen), 32'(fd_exp));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
